// File: rtl/mp_pkg.sv
// mp_pkg: controller state encoding and opcode constants shared with the fetch datapath
package mp_pkg;

    typedef enum logic [3:0] {
        Start    = 4'd0,
        PrepU    = 4'd1,
        FetchU   = 4'd2,
        PrepL    = 4'd3,
        FetchL   = 4'd4,
        Exec     = 4'd5,
        StoreMem = 4'd6,
        ReadMem  = 4'd7,
        Jump     = 4'd8
    } statetype;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ST  = 8'h03;
    localparam logic [7:0] OP_JMP = 8'h10;
    localparam logic [7:0] OP_JN  = 8'h11;
    localparam logic [7:0] OP_JNN = 8'h12;
    localparam logic [7:0] OP_JZ  = 8'h13;
    localparam logic [7:0] OP_JNZ = 8'h14;

    // Conditional branches are the only opcodes whose operand byte the controller may skip
    function automatic logic is_cond_branch(input logic [7:0] op);
        return op >= OP_JN && op <= OP_JNZ;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: controller/memory control lines and fetch datapath results
interface fetch_unit_if import mp_pkg::*; #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          FETCH;
    logic          LOAD_IRU;
    logic          LOAD_IRL;
    logic          INCR_PC;
    logic          LOAD_PC;
    logic          STORE_MEM;
    statetype      STATE;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] opcode;
    logic [AW-1:0] operand;
    logic [AW-1:0] pc;
    logic          skip_evt;
    logic          pc_wrap;

    modport master (
        output FETCH, LOAD_IRU, LOAD_IRL, INCR_PC, LOAD_PC, STORE_MEM, STATE, mem_rdata,
        input  mem_addr, mem_we, opcode, operand, pc, skip_evt, pc_wrap
    );

    modport slave (
        input  FETCH, LOAD_IRU, LOAD_IRL, INCR_PC, LOAD_PC, STORE_MEM, STATE, mem_rdata,
        output mem_addr, mem_we, opcode, operand, pc, skip_evt, pc_wrap
    );

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// pc_counter: program counter with load > increment > skip priority and sticky wrap flag
module pc_counter #(
    parameter int            AW     = 8,
    parameter logic [AW-1:0] RST_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          incr_i,
    input  logic          skip_i,
    input  logic [AW-1:0] load_val_i,
    output logic [AW-1:0] pc_o,
    output logic          wrap_o
);
    logic [AW-1:0] pc_q, pc_d;
    logic          wrap_q, wrap_d;
    logic          bump;

    // Next PC: a load overrides any increment; skip is just a late increment
    always_comb begin
        bump   = incr_i | skip_i;
        pc_d   = load_i ? load_val_i : bump ? pc_q + 1'b1 : pc_q;
        wrap_d = wrap_q | (!load_i && bump && &pc_q);
    end

    // PC and wrap flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= RST_PC;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign pc_o   = pc_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR datapath and memory address mux driven by the controller's control lines
module fetch_unit import mp_pkg::*; #(
    parameter int            AW     = 8,
    parameter int            DW     = 8,
    parameter logic [AW-1:0] RST_PC = '0
) (
    input logic         clk,
    input logic         reset,
    fetch_unit_if.slave bus
);
    logic [DW-1:0] iru_q, iru_d;
    logic [AW-1:0] irl_q, irl_d;
    logic [AW-1:0] pc;
    statetype      prev_q, prev_d;
    logic          skip_q, skip_d;

    // IR capture, state history, and detection of a not-taken branch returning PrepL->PrepU
    always_comb begin
        iru_d  = bus.LOAD_IRU ? bus.mem_rdata : iru_q;
        irl_d  = bus.LOAD_IRL ? AW'(bus.mem_rdata) : irl_q;
        prev_d = bus.STATE;
        skip_d = prev_q == PrepL && bus.STATE == PrepU && is_cond_branch(iru_q)
                 && !bus.INCR_PC && !bus.LOAD_PC;
    end

    // Register update; reset clears any pending fix-up along with everything else
    always_ff @(posedge clk) begin
        if (reset) begin
            iru_q  <= '0;
            irl_q  <= '0;
            prev_q <= Start;
            skip_q <= 1'b0;
        end else begin
            iru_q  <= iru_d;
            irl_q  <= irl_d;
            prev_q <= prev_d;
            skip_q <= skip_d;
        end
    end

    pc_counter #(.AW(AW), .RST_PC(RST_PC)) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load_i     (bus.LOAD_PC),
        .incr_i     (bus.INCR_PC),
        .skip_i     (skip_d),
        .load_val_i (AW'(bus.mem_rdata)),
        .pc_o       (pc),
        .wrap_o     (bus.pc_wrap)
    );

    // PC addresses instruction and jump-target bytes; IRL addresses operand data
    always_comb begin
        bus.mem_addr = (bus.FETCH | bus.LOAD_PC) ? pc : irl_q;
        bus.mem_we   = bus.STORE_MEM;
        bus.opcode   = iru_q;
        bus.operand  = irl_q;
        bus.pc       = pc;
        bus.skip_evt = skip_q;
    end

endmodule
